// File: rtl/ahb_lite_mem_slv.sv
// AHB-Lite slave memory with parametrised width, size and base, runtime wait states,
// two-cycle ERROR response for illegal accesses and a registered mailbox write strobe.
module ahb_lite_mem_slv #(
  parameter int unsigned   DW           = 64,
  parameter int unsigned   AW           = 64,
  parameter logic [AW-1:0] BASE_ADDR    = '0,
  parameter int unsigned   MEM_BYTES    = 'h10000,
  parameter logic [AW-1:0] MAILBOX_ADDR = AW'('hd0580000)
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic [DW-1:0] HWDATA,
  input  logic          HREADY,
  input  logic [3:0]    ws_cfg_i,
  input  logic [3:0]    ws_cfg_f,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [DW-1:0] HRDATA,
  output logic          mbox_valid,
  output logic [7:0]    mbox_data
);

  localparam int unsigned   NB       = DW / 8;
  localparam int unsigned   LB       = $clog2(NB);
  localparam int unsigned   WORDS    = MEM_BYTES / NB;
  localparam int unsigned   IW       = $clog2(WORDS);
  localparam logic [AW-1:0] END_ADDR = BASE_ADDR + AW'(MEM_BYTES);
  localparam int unsigned   MB_LANE  = int'(MAILBOX_ADDR[LB-1:0]);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            dp_q;
  logic            hready_q;
  logic            hresp_q;
  logic            mbox_valid_q;
  logic [7:0]      mbox_data_q;
  logic [IW-1:0]   word_q;
  logic            write_q;
  logic            mbox_q;
  logic [NB-1:0]   strb_q;
  logic [DW-1:0]   mem_q [WORDS];

  logic            acc;
  logic            done;
  logic            is_mbox;
  logic            in_range;
  logic            misal;
  logic            illegal_d;
  logic [AW-1:0]   off;
  logic [NB-1:0]   strb_d;
  logic [IW-1:0]   word_d;
  logic [3:0]      ws_d;
  int              lane;
  int              nbytes;
  logic            unused_ok;

  // A new address phase is only taken when this slave is able to start one.
  assign acc  = HSEL & HREADY & HTRANS[1] & ((state_q == IDLE) | (state_q == ERR2));
  assign done = dp_q & hready_q;

  always_comb begin
    off       = HADDR - BASE_ADDR;
    is_mbox   = (HADDR == MAILBOX_ADDR);
    in_range  = (HADDR >= BASE_ADDR) && (HADDR < END_ADDR);
    misal     = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if ((i < int'(HSIZE)) && HADDR[i]) misal = 1'b1;
    end
    illegal_d = !is_mbox && ((HSIZE > 3'(LB)) || misal || !in_range);
    lane      = int'(HADDR[LB-1:0]);
    nbytes    = 1 << HSIZE;
    strb_d    = '0;
    for (int b = 0; b < NB; b++) begin
      strb_d[b] = (b >= lane) && (b < lane + nbytes);
    end
    word_d    = off[IW+LB-1:LB];
    ws_d      = HPROT[0] ? ws_cfg_i : ws_cfg_f;
  end

  assign unused_ok = ^{HBURST, HPROT[3:1], HTRANS[0], off[LB-1:0], off[AW-1:IW+LB]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dp_q         <= 1'b0;
      hready_q     <= 1'b1;
      hresp_q      <= 1'b0;
      mbox_valid_q <= 1'b0;
      mbox_data_q  <= '0;
    end else begin
      mbox_valid_q <= done & write_q & mbox_q;
      if (done & write_q & mbox_q) mbox_data_q <= HWDATA[8*MB_LANE +: 8];
      if (done) dp_q <= 1'b0;
      case (state_q)
        IDLE, ERR2: begin
          state_q  <= IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (acc) begin
            if (illegal_d) begin
              state_q  <= ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
              dp_q     <= 1'b0;
            end else begin
              dp_q <= 1'b1;
              if (ws_d != 4'd0) begin
                state_q  <= WAIT;
                cnt_q    <= ws_d - 4'd1;
                hready_q <= 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q  <= IDLE;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ERR1: begin
          state_q  <= ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address-phase attributes; only meaningful while dp_q is set.
  always_ff @(posedge HCLK) begin
    if (acc) begin
      word_q  <= word_d;
      write_q <= HWRITE;
      mbox_q  <= is_mbox;
      strb_q  <= strb_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (done & write_q & !mbox_q) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_q[b]) mem_q[word_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT  = hready_q;
  assign HRESP      = hresp_q;
  assign HRDATA     = (done & !write_q & !mbox_q) ? mem_q[word_q] : '0;
  assign mbox_valid = mbox_valid_q;
  assign mbox_data  = mbox_data_q;

endmodule

// File: tb/tb_ahb_lite_mem_slv.sv
// Directed bench for ahb_lite_mem_slv: table of single transfers plus hand-written
// pipelined, error-recovery, mailbox, foreign-HREADY and reset-in-wait sequences.
module tb_ahb_lite_mem_slv;

  localparam logic [63:0] B    = 64'h1000_0000;
  localparam logic [63:0] MBOX = 64'hd058_0000;
  localparam logic [63:0] D1   = 64'h1122334455667788;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [63:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        hready_ext;
  logic [3:0]  ws_cfg_i;
  logic [3:0]  ws_cfg_f;
  logic        HREADYOUT;
  logic        HRESP;
  logic [63:0] HRDATA;
  logic        mbox_valid;
  logic [7:0]  mbox_data;

  int n_tests = 0;
  int n_fail  = 0;

  assign HREADY = HREADYOUT & hready_ext;

  ahb_lite_mem_slv #(
    .DW(64), .AW(64), .BASE_ADDR(B), .MEM_BYTES('h10000), .MAILBOX_ADDR(MBOX)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADY(HREADY), .ws_cfg_i(ws_cfg_i), .ws_cfg_f(ws_cfg_f), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .mbox_valid(mbox_valid), .mbox_data(mbox_data)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [63:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic        prot;
    logic [63:0] wdata;
    logic [3:0]  wsi;
    logic [3:0]  wsf;
    logic [63:0] exp_rd;
    logic        exp_rsp;
    int          exp_nw;
  } vec_t;

  vec_t vec[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic addr_phase(input logic [63:0] a, input logic w, input logic [2:0] sz,
                            input logic p);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = sz; HPROT = {3'b000, p};
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic do_xfer(input logic [63:0] a, input logic w, input logic [2:0] sz,
                         input logic p, input logic [63:0] wd,
                         output logic [63:0] rd, output logic rsp, output int nw);
    addr_phase(a, w, sz, p);
    tick();
    bus_idle();
    HWDATA = wd;
    nw = 0;
    while (HREADYOUT !== 1'b1 && nw < 20) begin
      tick();
      nw++;
    end
    rd  = HRDATA;
    rsp = HRESP;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    logic        rsp;
    int          nw;

    vec[0]  = '{B+8,       1'b1, 3'd3, 1'b1, D1,                    4'd0, 4'd0, 64'h0,                 1'b0, 0};
    vec[1]  = '{B+8,       1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd0, D1,                    1'b0, 0};
    vec[2]  = '{B+5,       1'b1, 3'd0, 1'b1, 64'h0000AB0000000000,  4'd3, 4'd0, 64'h0,                 1'b0, 3};
    vec[3]  = '{B+0,       1'b0, 3'd3, 1'b1, 64'h0,                 4'd3, 4'd0, 64'h0000AB0000000000,  1'b0, 3};
    vec[4]  = '{B+'h10000, 1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd0, 64'h0,                 1'b1, 1};
    vec[5]  = '{B+1,       1'b0, 3'd1, 1'b1, 64'h0,                 4'd0, 4'd0, 64'h0,                 1'b1, 1};
    vec[6]  = '{B+0,       1'b0, 3'd4, 1'b1, 64'h0,                 4'd0, 4'd0, 64'h0,                 1'b1, 1};
    vec[7]  = '{B-8,       1'b1, 3'd3, 1'b1, 64'hFFFFFFFFFFFFFFFF,  4'd0, 4'd0, 64'h0,                 1'b1, 1};
    vec[8]  = '{B+9,       1'b1, 3'd3, 1'b1, 64'hFFFFFFFFFFFFFFFF,  4'd0, 4'd0, 64'h0,                 1'b1, 1};
    vec[9]  = '{B+8,       1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd0, D1,                    1'b0, 0};
    vec[10] = '{B+'hFFFC,  1'b1, 3'd2, 1'b1, 64'hDEADBEEF00000000,  4'd0, 4'd0, 64'h0,                 1'b0, 0};
    vec[11] = '{B+'hFFF8,  1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd0, 64'hDEADBEEF00000000,  1'b0, 0};
    vec[12] = '{B+'h12,    1'b1, 3'd1, 1'b1, 64'h0000000055660000,  4'd0, 4'd0, 64'h0,                 1'b0, 0};
    vec[13] = '{B+'h10,    1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd0, 64'h0000000055660000,  1'b0, 0};
    vec[14] = '{B+8,       1'b0, 3'd3, 1'b0, 64'h0,                 4'd0, 4'd2, D1,                    1'b0, 2};
    vec[15] = '{B+8,       1'b0, 3'd3, 1'b1, 64'h0,                 4'd0, 4'd2, D1,                    1'b0, 0};
    vec[16] = '{MBOX,      1'b0, 3'd0, 1'b1, 64'h0,                 4'd0, 4'd0, 64'h0,                 1'b0, 0};

    HRESETn = 1'b0; hready_ext = 1'b1;
    HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = '0;
    HBURST = '0; HPROT = 4'b0001; HWDATA = '0; ws_cfg_i = '0; ws_cfg_f = '0;
    repeat (3) tick();
    chk("rst_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("rst_hresp", 64'(HRESP), 64'h0);
    chk("rst_hrdata", HRDATA, 64'h0);
    chk("rst_mbox_valid", 64'(mbox_valid), 64'h0);
    chk("rst_mbox_data", 64'(mbox_data), 64'h0);
    HRESETn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      ws_cfg_i = vec[i].wsi;
      ws_cfg_f = vec[i].wsf;
      do_xfer(vec[i].addr, vec[i].wr, vec[i].sz, vec[i].prot, vec[i].wdata, rd, rsp, nw);
      chk($sformatf("vec%0d_resp", i), 64'(rsp), 64'(vec[i].exp_rsp));
      chk($sformatf("vec%0d_waits", i), 64'(nw), 64'(vec[i].exp_nw));
      chk($sformatf("vec%0d_rdata", i), rd, vec[i].exp_rd);
    end
    ws_cfg_i = '0; ws_cfg_f = '0;

    // Pipelined write then read of the same word.
    addr_phase(B+'h20, 1'b1, 3'd3, 1'b1);
    tick();
    chk("b2b_wr_hreadyout", 64'(HREADYOUT), 64'h1);
    HWDATA = 64'hA5A5010203045A5A;
    addr_phase(B+'h20, 1'b0, 3'd3, 1'b1);
    tick();
    bus_idle();
    chk("b2b_rd_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("b2b_rd_data", HRDATA, 64'hA5A5010203045A5A);
    tick();

    // Error response, then a new transfer accepted in ERR2.
    addr_phase(B+1, 1'b0, 3'd1, 1'b1);
    tick();
    bus_idle();
    chk("err1_hreadyout", 64'(HREADYOUT), 64'h0);
    chk("err1_hresp", 64'(HRESP), 64'h1);
    tick();
    chk("err2_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("err2_hresp", 64'(HRESP), 64'h1);
    addr_phase(B+8, 1'b0, 3'd3, 1'b1);
    tick();
    bus_idle();
    chk("post_err_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("post_err_hresp", 64'(HRESP), 64'h0);
    chk("post_err_rdata", HRDATA, D1);
    tick();

    // Mailbox write.
    addr_phase(MBOX, 1'b1, 3'd0, 1'b1);
    tick();
    bus_idle();
    HWDATA = 64'h00000000000000FF;
    chk("mbox_dp_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("mbox_dp_hresp", 64'(HRESP), 64'h0);
    chk("mbox_dp_valid", 64'(mbox_valid), 64'h0);
    tick();
    chk("mbox_pulse_valid", 64'(mbox_valid), 64'h1);
    chk("mbox_pulse_data", 64'(mbox_data), 64'hFF);
    tick();
    chk("mbox_pulse_end", 64'(mbox_valid), 64'h0);

    // HREADY held low by another slave: nothing may be accepted.
    hready_ext = 1'b0;
    addr_phase(B+8, 1'b1, 3'd3, 1'b1);
    HWDATA = 64'h0BADC0DE0BADC0DE;
    tick();
    tick();
    chk("fhr_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("fhr_hresp", 64'(HRESP), 64'h0);
    bus_idle();
    hready_ext = 1'b1;
    tick();
    do_xfer(B+8, 1'b0, 3'd3, 1'b1, 64'h0, rd, rsp, nw);
    chk("fhr_readback", rd, D1);

    // Reset asserted during the wait states of a write.
    ws_cfg_i = 4'd3;
    addr_phase(B+8, 1'b1, 3'd3, 1'b1);
    tick();
    bus_idle();
    HWDATA = 64'hCAFEF00DCAFEF00D;
    chk("rstw_wait_hreadyout", 64'(HREADYOUT), 64'h0);
    tick();
    HRESETn = 1'b0;
    #1;
    chk("rstw_async_hreadyout", 64'(HREADYOUT), 64'h1);
    chk("rstw_async_hresp", 64'(HRESP), 64'h0);
    tick();
    HRESETn = 1'b1;
    ws_cfg_i = 4'd0;
    tick();
    do_xfer(B+8, 1'b0, 3'd3, 1'b1, 64'h0, rd, rsp, nw);
    chk("rstw_readback", rd, D1);
    chk("rstw_readback_resp", 64'(rsp), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
